pool_stage_sequencer: RTL
=========================

POOL_STAGE_SEQUENCER -- requirements
Module: pool_stage_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 4095, watchdog limit in cycles per stage; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of watchdog counter; SHALL satisfy 2^CNT_W > TIMEOUT.
REQ-003 S_AXIS_ACLK  input  1  clock; all logic on rising edge.
REQ-004 S_AXIS_ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to run the five-stage sequence.
REQ-006 abort  input  1  synchronous cancel of the running sequence.
REQ-007 stage_rdy  input  5  per-stage ready/elapsed flags from the stage timers, bit k = stage k.
REQ-008 stage_en  output  5  per-stage enable/hold-high request to the stage timers, at most one bit set.
REQ-009 stage_idx  output  3  index of the active stage, 0..4; 0 when not running.
REQ-010 busy  output  1  high while a sequence is in progress.
REQ-011 done  output  1  one-cycle pulse on successful completion of stage 4.
REQ-012 err  output  1  sticky watchdog-timeout flag.

Function
REQ-013 States SHALL be IDLE, RUN, DONE and ERR, with stage index k in 0..4 held in RUN.
REQ-014 In IDLE, start=1 and abort=0 SHALL enter RUN with k=0 and clear err; stage_en[0]=1 and busy=1 SHALL appear the cycle after start is sampled.
REQ-015 In RUN, stage_en SHALL equal one-hot(k) and stage_idx SHALL equal k, both held level until the stage is left.
REQ-016 In RUN, stage_rdy[k]=1 sampled with k<4 SHALL advance k to k+1, so stage_en[k] falls and stage_en[k+1] rises on the same next edge; no gap cycle and no overlap.
REQ-017 In RUN, stage_rdy[4]=1 sampled SHALL enter DONE: stage_en=0, done=1 for exactly one cycle, busy=0 in DONE; DONE then returns unconditionally to IDLE.
REQ-018 stage_rdy bits other than bit k SHALL be ignored; stage_rdy already high on stage entry SHALL advance after a single RUN cycle for that stage.
REQ-019 A watchdog counter SHALL clear on every stage entry and increment each RUN cycle; the counter reaching TIMEOUT-1 with stage_rdy[k]=0 SHALL enter ERR.
REQ-020 If stage_rdy[k]=1 in the same cycle the watchdog expires, ready SHALL win and the sequence SHALL advance normally.
REQ-021 ERR SHALL drive stage_en=0, busy=0, err=1, stage_idx=0, and SHALL return to IDLE the next cycle; err SHALL stay high until the next accepted start.
REQ-022 abort=1 in RUN SHALL return to IDLE on the next edge with stage_en=0, busy=0, and no done pulse; err is unaffected.
REQ-023 abort=1 and start=1 together in IDLE SHALL keep the block in IDLE.
REQ-024 start while busy=1, or while in DONE or ERR, SHALL be ignored and not queued.
REQ-025 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-026 Reset SHALL force IDLE, k=0, watchdog counter=0, stage_en=0, stage_idx=0, busy=0, done=0, err=0, asynchronously on assertion, including in the middle of a sequence.
REQ-027 Reset deassertion SHALL be followed by no output change until a start is sampled.

Verification
REQ-028 Stage timer models with ready after 17/14/0/16/238 cycles of enable, start pulse -> stage_en walks 0x01,0x02,0x04,0x08,0x10 one-hot with no gap; done pulses once; busy falls with done.
REQ-029 TIMEOUT=32, stage 1 ready never asserted -> ERR exactly 32 cycles after stage_en[1] rises; err=1, stage_en=0; the next start clears err.
REQ-030 Stage 3 ready asserted on the exact watchdog-expiry cycle -> advance to stage 4, err stays 0.
REQ-031 abort during stage 2 -> stage_en=0 next cycle, no done; start in the following cycle -> restart at stage 0.
REQ-032 Second start pulse during stage 0, and start+abort together in IDLE -> both ignored, sequence timing unchanged.
REQ-033 Reset asserted mid-stage 4 -> all outputs 0 immediately, without a clock edge; no done after release.

Source files
------------

// File: rtl/pool_stage_sequencer.sv
// pool_stage_sequencer: walks five external stage timers in order (0..4),
// holding one stage enable high at a time and advancing when that stage's
// ready flag is sampled. A per-stage watchdog aborts to ERR if a stage never
// reports ready. All outputs come straight from flops.
//
// Handshake: stage_en[k] is a level request held for the whole stage;
// stage_rdy[k] is only looked at while stage k is active, and the first
// rising edge that samples it high ends the stage (no separate ack). start
// is a single-cycle request accepted only in IDLE; it is never queued.
module pool_stage_sequencer #(
  parameter int TIMEOUT = 4095,
  parameter int CNT_W   = 16
) (
  input  logic       S_AXIS_ACLK,
  input  logic       S_AXIS_ARESETN,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] stage_rdy,
  output logic [4:0] stage_en,
  output logic [2:0] stage_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [2:0]       LAST_STAGE = 3'd4;
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [4:0]       stage_en_q, stage_en_d;
  logic [2:0]       stage_idx_q, stage_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next state, stage index, watchdog and the registered output images.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (start && !abort) begin
          state_d = ST_RUN;
          k_d     = 3'd0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          k_d     = 3'd0;
          wd_d    = '0;
        end else if (stage_rdy[k_q]) begin
          // Ready beats a watchdog expiry landing in the same cycle.
          wd_d = '0;
          if (k_q == LAST_STAGE) begin
            state_d = ST_DONE;
            k_d     = 3'd0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = ST_ERR;
          k_d     = 3'd0;
          wd_d    = '0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step.
    stage_en_d  = (state_d == ST_RUN) ? (5'b00001 << k_d) : 5'b00000;
    stage_idx_d = (state_d == ST_RUN) ? k_d : 3'd0;
    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q     <= ST_IDLE;
      k_q         <= 3'd0;
      wd_q        <= '0;
      stage_en_q  <= 5'b00000;
      stage_idx_q <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wd_q        <= wd_d;
      stage_en_q  <= stage_en_d;
      stage_idx_q <= stage_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign stage_en  = stage_en_q;
  assign stage_idx = stage_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
